hawk_tbl_rd_engine: RTL and testbench
=====================================

Name: hawk_tbl_rd_engine

Overview:
- Sequential table-read engine for the HACD chipset block. It turns ATT and TOL list-entry lookups, given as a 1-based entry ID, into single-beat 64-byte AXI reads.
- It extracts and returns the addressed entry.
- Generalised over entry widths, entries per line and base addresses.
- Adds a per-table one-line buffer, so back-to-back lookups in the same cache line skip AXI. Sits between the page/compression managers and the AXI read port.

Parameters:
- ADDR_W, 64, AXI address width
- DATA_W, 512, AXI data width = cache line bits (line = DATA_W/8 bytes)
- ID_W, 20, entry ID width
- ATT_BASE, 64'h8000_0000, ATT table byte base
- LST_BASE, 64'h8010_0000, list table byte base
- ATT_ENTRY_W, 64, ATT entry bits (ATT_EPL = DATA_W/ATT_ENTRY_W)
- LST_ENTRY_W, 128, list entry bits (LST_EPL = DATA_W/LST_ENTRY_W); the wider of the two entry widths is called MAX_W
- AXI_ID, 0, constant ARID
- LBUF_EN, 1, 1 enables the line buffers

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  lookup request valid
- req_ready_o  out  1  engine can accept a request
- req_type_i  in  1  0=ATT, 1=LST
- req_id_i  in  ID_W  1-based entry ID
- flush_i  in  1  invalidate both line buffers
- ar_valid_o  out  1  AXI AR valid
- ar_ready_i  in  1  AXI AR ready
- ar_addr_o  out  ADDR_W  line-aligned address
- ar_id_o  out  AXI ID  = AXI_ID
- ar_len_o  out  8  constant 0
- ar_size_o  out  3  constant log2(DATA_W/8)
- r_valid_i  in  1  AXI R valid
- r_ready_o  out  1  AXI R ready
- r_data_i  in  DATA_W  read data
- r_resp_i  in  2  read response
- r_last_i  in  1  last beat
- rsp_valid_o  out  1  lookup result valid
- rsp_ready_i  in  1  result consumed
- rsp_entry_o  out  MAX_W  entry, zero-extended
- rsp_err_o  out  1  lookup failed
- rsp_hit_o  out  1  result came from the line buffer

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; all outputs 0 except the constant AR fields; both buffer valid bits 0.
- Reset mid-transaction abandons the transaction. Any R beat arriving after reset is accepted and dropped in IDLE, because r_ready_o=1 in IDLE only for a stray beat with no outstanding request.
- Index math, with k = req_id-1 and EPL = ATT_EPL or LST_EPL by type:
  - line = k / EPL
  - slot = k % EPL
  - addr = BASE + line*(DATA_W/8), computed mod 2^ADDR_W
  - entry = data[slot*ENTRY_W +: ENTRY_W]
  - EPL is a power of two, so use shift/mask only.
- FSM states: IDLE, AR, R, RSP. req_ready_o = (state==IDLE). A request is accepted on req_valid_i & req_ready_o.
- IDLE, on accept:
  - id==0 -> RSP with err=1, entry=0, no AXI.
  - Else, buffer hit (LBUF_EN, valid[type], tag[type]==line, and flush_i=0 that cycle) -> RSP with hit=1.
  - Else -> AR.
  - Result latches at accept; rsp_valid_o rises the next cycle (1-cycle hit latency).
- AR: ar_valid_o=1 and ar_addr_o held stable until ar_ready_i; then go to R.
- R: r_ready_o=1. On r_valid_i:
  - If r_resp_i==OKAY and r_last_i==1, extract the entry, write buffer[type] (data, tag, valid=1) unless flush_i is high that cycle, err=0.
  - Otherwise err=1, entry=0, buffer[type] invalidated.
  - Then go to RSP.
- RSP: rsp_valid_o=1 with entry/err/hit held stable until rsp_ready_i, then go to IDLE. There is no combinational path from req to rsp.
- flush_i clears both valid bits in any state. Flush coincident with a fill: flush wins, nothing is written.
- ATT and LST buffers are independent. Only a lookup of type T affects buffer T.
- The engine has one outstanding transaction at most; AR is never issued before the previous R has completed.

Test Plan:
- ATT id 9, ar_ready_i after 3 wait cycles -> ar_addr_o=0x8000_0040 held all 4 cycles. R data with bits[63:0]=0xDEAD -> rsp_entry_o=0xDEAD, hit=0, err=0.
- LST id 6 -> ar_addr_o=0x8010_0040, slot 1. rsp_entry_o=r_data_i[255:128], zero-extended to MAX_W.
- After the ATT id 9 fill, request ATT id 12 -> no AR. rsp_valid_o high 1 cycle after accept, hit=1, entry=buffered bits[255:192].
- Read with r_resp_i=2'b10 for ATT id 9 -> err=1, entry=0. A following ATT id 10 misses and issues AR to 0x8000_0040.
- flush_i asserted in the same cycle as the R beat for LST id 1 -> response returned normally. The next LST id 2 misses and reissues AR to 0x8010_0000.
- Request id 0 -> err=1 one cycle later, ar_valid_o stays 0. Hold rsp_ready_i=0 for 5 cycles -> outputs stable, req_ready_o=0 throughout.

Source files
------------

// File: rtl/hawk_tbl_rd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : hawk_tbl_rd_engine
//  Purpose  : Sequential ATT / list-table entry reader. Converts a 1-based
//             entry ID into a single-beat line read on AXI, extracts the
//             addressed entry and keeps one cached line per table so that
//             lookups landing in the same line return without AXI traffic.
//  Revision : 1.0  initial release
// ============================================================================
module hawk_tbl_rd_engine #(
  parameter int          ADDR_W      = 64,
  parameter int          DATA_W      = 512,
  parameter int          ID_W        = 20,
  parameter logic [63:0] ATT_BASE    = 64'h8000_0000,
  parameter logic [63:0] LST_BASE    = 64'h8010_0000,
  parameter int          ATT_ENTRY_W = 64,
  parameter int          LST_ENTRY_W = 128,
  parameter int          AXI_ID      = 0,
  parameter int          AXI_ID_W    = 4,
  parameter bit          LBUF_EN     = 1'b1,
  // Derived; not meant to be overridden.
  parameter int          MAX_W       = (ATT_ENTRY_W > LST_ENTRY_W) ? ATT_ENTRY_W : LST_ENTRY_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // lookup request
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_type_i,
  input  logic [ID_W-1:0]     req_id_i,
  input  logic                flush_i,
  // AXI read address channel
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  output logic [ADDR_W-1:0]   ar_addr_o,
  output logic [AXI_ID_W-1:0] ar_id_o,
  output logic [7:0]          ar_len_o,
  output logic [2:0]          ar_size_o,
  // AXI read data channel
  input  logic                r_valid_i,
  output logic                r_ready_o,
  input  logic [DATA_W-1:0]   r_data_i,
  input  logic [1:0]          r_resp_i,
  input  logic                r_last_i,
  // lookup response
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [MAX_W-1:0]    rsp_entry_o,
  output logic                rsp_err_o,
  output logic                rsp_hit_o
);

  localparam int c_line_bytes = DATA_W / 8;
  localparam int c_line_sh    = $clog2(c_line_bytes);
  localparam int c_att_epl    = DATA_W / ATT_ENTRY_W;
  localparam int c_lst_epl    = DATA_W / LST_ENTRY_W;
  localparam int c_att_sh     = $clog2(c_att_epl);
  localparam int c_lst_sh     = $clog2(c_lst_epl);
  localparam int c_slot_raw   = (c_att_sh > c_lst_sh) ? c_att_sh : c_lst_sh;
  localparam int c_slot_w     = (c_slot_raw > 0) ? c_slot_raw : 1;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_AR   = 2'd1;
  localparam logic [1:0] c_S_R    = 2'd2;
  localparam logic [1:0] c_S_RSP  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;

  logic                r_type;
  logic [ID_W-1:0]     r_line;
  logic [c_slot_w-1:0] r_slot;
  logic [ADDR_W-1:0]   r_addr;
  logic [MAX_W-1:0]    r_entry;
  logic                r_err;
  logic                r_hit;

  logic                r_att_vld;
  logic [ID_W-1:0]     r_att_tag;
  logic [DATA_W-1:0]   r_att_data;
  logic                r_lst_vld;
  logic [ID_W-1:0]     r_lst_tag;
  logic [DATA_W-1:0]   r_lst_data;

  logic                w_req_ready;
  logic                w_ar_valid;
  logic                w_r_ready;
  logic                w_rsp_valid;

  logic                w_accept;
  logic                w_id_zero;
  logic [ID_W-1:0]     w_k;
  logic [ID_W-1:0]     w_line;
  logic [c_slot_w-1:0] w_slot;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_hit;
  logic [MAX_W-1:0]    w_buf_entry;
  logic [MAX_W-1:0]    w_fill_entry;
  logic                w_beat;
  logic                w_r_ok;

  // Pick entry 'slot' of the given table type out of a full line, zero-extended.
  function automatic logic [MAX_W-1:0] f_extract(input logic          typ,
                                                 input logic [DATA_W-1:0]   data,
                                                 input logic [c_slot_w-1:0] slot);
    logic [MAX_W-1:0] v_out;
    v_out = '0;
    for (int i = 0; i < c_att_epl; i++) begin
      if (!typ && slot == c_slot_w'(i))
        v_out = MAX_W'(data[i*ATT_ENTRY_W +: ATT_ENTRY_W]);
    end
    for (int i = 0; i < c_lst_epl; i++) begin
      if (typ && slot == c_slot_w'(i))
        v_out = MAX_W'(data[i*LST_ENTRY_W +: LST_ENTRY_W]);
    end
    return v_out;
  endfunction

  // Request decode: EPL is a power of two, so line/slot are a shift and a mask.
  always_comb begin
    w_accept  = req_valid_i && w_req_ready;
    w_id_zero = (req_id_i == '0);
    w_k       = req_id_i - ID_W'(1);
    if (req_type_i) begin
      w_line = w_k >> c_lst_sh;
      w_slot = c_slot_w'(w_k & ID_W'(c_lst_epl - 1));
      w_addr = ADDR_W'(LST_BASE) + (ADDR_W'(w_line) << c_line_sh);
      w_hit  = LBUF_EN && r_lst_vld && (r_lst_tag == w_line);
    end else begin
      w_line = w_k >> c_att_sh;
      w_slot = c_slot_w'(w_k & ID_W'(c_att_epl - 1));
      w_addr = ADDR_W'(ATT_BASE) + (ADDR_W'(w_line) << c_line_sh);
      w_hit  = LBUF_EN && r_att_vld && (r_att_tag == w_line);
    end
    // a flush in the accept cycle forbids using the buffer
    w_hit        = w_hit && !w_id_zero && !flush_i;
    w_buf_entry  = f_extract(req_type_i, req_type_i ? r_lst_data : r_att_data, w_slot);
    w_fill_entry = f_extract(r_type, r_data_i, r_slot);
    w_beat       = (r_state == c_S_R) && r_valid_i;
    w_r_ok       = (r_resp_i == 2'b00) && r_last_i;
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= c_S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (w_accept)    w_state_nxt = (w_id_zero || w_hit) ? c_S_RSP : c_S_AR;
      c_S_AR:   if (ar_ready_i)  w_state_nxt = c_S_R;
      c_S_R:    if (r_valid_i)   w_state_nxt = c_S_RSP;
      c_S_RSP:  if (rsp_ready_i) w_state_nxt = c_S_IDLE;
      default:                   w_state_nxt = c_S_IDLE;
    endcase
  end

  // FSM outputs; in IDLE a stray R beat (left over from an abandoned read) is drained.
  always_comb begin
    w_req_ready = (r_state == c_S_IDLE);
    w_ar_valid  = (r_state == c_S_AR);
    w_r_ready   = (r_state == c_S_R) || ((r_state == c_S_IDLE) && r_valid_i);
    w_rsp_valid = (r_state == c_S_RSP);
  end

  // Per-lookup context and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_type  <= 1'b0;
      r_line  <= '0;
      r_slot  <= '0;
      r_addr  <= '0;
      r_entry <= '0;
      r_err   <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_type  <= req_type_i;
        r_line  <= w_line;
        r_slot  <= w_slot;
        r_addr  <= w_addr;
        r_hit   <= w_hit;
        r_err   <= w_id_zero;
        r_entry <= w_hit ? w_buf_entry : '0;
      end
      if (w_beat) begin
        r_entry <= w_r_ok ? w_fill_entry : '0;
        r_err   <= !w_r_ok;
      end
    end
  end

  // Line-buffer valid bits; flush is applied last so it beats a coincident fill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_att_vld <= 1'b0;
      r_lst_vld <= 1'b0;
    end else begin
      if (w_beat) begin
        if (r_type) r_lst_vld <= w_r_ok;
        else        r_att_vld <= w_r_ok;
      end
      if (flush_i) begin
        r_att_vld <= 1'b0;
        r_lst_vld <= 1'b0;
      end
    end
  end

  // Line-buffer data and tags, only captured by a good, unflushed fill.
  always_ff @(posedge clk_i) begin
    if (w_beat && w_r_ok && !flush_i) begin
      if (r_type) begin
        r_lst_data <= r_data_i;
        r_lst_tag  <= r_line;
      end else begin
        r_att_data <= r_data_i;
        r_att_tag  <= r_line;
      end
    end
  end

  assign req_ready_o = w_req_ready;
  assign ar_valid_o  = w_ar_valid;
  assign ar_addr_o   = r_addr;
  assign ar_id_o     = AXI_ID_W'(AXI_ID);
  assign ar_len_o    = 8'd0;
  assign ar_size_o   = 3'(c_line_sh);
  assign r_ready_o   = w_r_ready;
  assign rsp_valid_o = w_rsp_valid;
  assign rsp_entry_o = r_entry;
  assign rsp_err_o   = r_err;
  assign rsp_hit_o   = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_hawk_tbl_rd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hawk_tbl_rd_engine
//  Purpose  : Self-checking bench for hawk_tbl_rd_engine with a line-level
//             reference model of both table buffers.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hawk_tbl_rd_engine;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_type_i;
  logic [19:0]   req_id_i;
  logic          flush_i;
  logic          ar_valid_o;
  logic          ar_ready_i;
  logic [63:0]   ar_addr_o;
  logic [3:0]    ar_id_o;
  logic [7:0]    ar_len_o;
  logic [2:0]    ar_size_o;
  logic          r_valid_i;
  logic          r_ready_o;
  logic [511:0]  r_data_i;
  logic [1:0]    r_resp_i;
  logic          r_last_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [127:0]  rsp_entry_o;
  logic          rsp_err_o;
  logic          rsp_hit_o;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: one cached line per table type
  bit           m_vld [2];
  int           m_tag [2];
  logic [511:0] m_dat [2];

  hawk_tbl_rd_engine dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_type_i(req_type_i), .req_id_i(req_id_i), .flush_i(flush_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_entry_o(rsp_entry_o), .rsp_err_o(rsp_err_o), .rsp_hit_o(rsp_hit_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] entry_of(input logic [511:0] line, input int slot, input int w);
    logic [511:0] mask;
    mask = {512{1'b1}} >> (512 - w);
    return (line >> (slot * w)) & mask;
  endfunction

  // One complete lookup: request, optional AXI exchange, response with backpressure.
  task automatic lookup(input bit typ, input int id, input logic [511:0] data,
                        input bit bad, input bit fl_a, input bit fl_r,
                        input int arw, input int hold);
    int           k, epl, w, line, slot;
    logic [63:0]  addr;
    bit           hit;
    logic [511:0] exp_e;
    bit           exp_err;
    @(negedge clk_i);
    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_type_i  = typ;
    req_id_i    = 20'(id);
    flush_i     = fl_a;
    epl = typ ? 4 : 8;
    w   = typ ? 128 : 64;
    k = 0; line = 0; slot = 0; addr = '0;
    hit = 1'b0;
    if (id != 0) begin
      k    = id - 1;
      line = k / epl;
      slot = k % epl;
      addr = (typ ? 64'h8010_0000 : 64'h8000_0000) + 64'(line) * 64;
      hit  = m_vld[typ] && (m_tag[typ] == line) && !fl_a;
    end
    if (fl_a) begin m_vld[0] = 1'b0; m_vld[1] = 1'b0; end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    if (id == 0) begin
      exp_e = '0; exp_err = 1'b1;
      chk("idzero_no_ar", ar_valid_o, 0);
    end else if (hit) begin
      exp_e = entry_of(m_dat[typ], slot, w); exp_err = 1'b0;
      chk("hit_no_ar", ar_valid_o, 0);
    end else begin
      chk("ar_valid", ar_valid_o, 1);
      chk("ar_addr", ar_addr_o, addr);
      for (int i = 0; i < arw; i++) begin
        @(negedge clk_i);
        chk("ar_valid_hold", ar_valid_o, 1);
        chk("ar_addr_hold", ar_addr_o, addr);
      end
      ar_ready_i = 1'b1;
      @(negedge clk_i);
      ar_ready_i = 1'b0;
      chk("ar_drop", ar_valid_o, 0);
      chk("rsp_not_early", rsp_valid_o, 0);
      r_valid_i = 1'b1;
      r_data_i  = data;
      r_resp_i  = bad ? 2'b10 : 2'b00;
      r_last_i  = 1'b1;
      flush_i   = fl_r;
      #1;
      chk("r_ready", r_ready_o, 1);
      @(negedge clk_i);
      r_valid_i = 1'b0;
      flush_i   = 1'b0;
      if (bad) begin
        exp_e = '0; exp_err = 1'b1;
        m_vld[typ] = 1'b0;
      end else begin
        exp_e = entry_of(data, slot, w); exp_err = 1'b0;
        m_vld[typ] = 1'b1; m_tag[typ] = line; m_dat[typ] = data;
      end
      if (fl_r) begin m_vld[0] = 1'b0; m_vld[1] = 1'b0; end
    end
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_entry", rsp_entry_o, exp_e);
    chk("rsp_err", rsp_err_o, exp_err);
    chk("rsp_hit", rsp_hit_o, hit);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_entry", rsp_entry_o, exp_e);
      chk("hold_err", rsp_err_o, exp_err);
      chk("hold_hit", rsp_hit_o, hit);
      chk("hold_req_ready", req_ready_o, 0);
      chk("hold_ar_valid", ar_valid_o, 0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("rsp_done", rsp_valid_o, 0);
  endtask

  initial begin
    logic [511:0] d;
    rst_i = 1'b1; req_valid_i = 1'b0; req_type_i = 1'b0; req_id_i = '0; flush_i = 1'b0;
    ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0; r_last_i = 1'b0;
    rsp_ready_i = 1'b0;
    m_vld[0] = 1'b0; m_vld[1] = 1'b0; m_tag[0] = 0; m_tag[1] = 0;
    m_dat[0] = '0; m_dat[1] = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // reset state
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_ar_valid", ar_valid_o, 0);
    chk("rst_r_ready", r_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_entry", rsp_entry_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_hit", rsp_hit_o, 0);
    chk("rst_ar_addr", ar_addr_o, 0);
    chk("ar_len", ar_len_o, 0);
    chk("ar_size", ar_size_o, 6);
    chk("ar_id", ar_id_o, 0);

    // directed scenarios
    d = rand_line(); d[63:0] = 64'hDEAD;
    lookup(1'b0, 9, d, 0, 0, 0, 3, 1);       // ATT miss, 3 AR wait cycles
    lookup(1'b1, 6, rand_line(), 0, 0, 0, 0, 0);  // LST slot 1
    lookup(1'b0, 12, '0, 0, 0, 0, 0, 0);     // ATT buffer hit, slot 3
    lookup(1'b0, 9, rand_line(), 1, 0, 0, 1, 0);  // SLVERR response
    lookup(1'b0, 10, rand_line(), 0, 0, 0, 0, 0); // misses again after error
    lookup(1'b1, 1, rand_line(), 0, 0, 1, 0, 0);  // flush coincides with fill
    lookup(1'b1, 2, rand_line(), 0, 0, 0, 0, 0);  // must miss
    lookup(1'b0, 0, '0, 0, 0, 0, 0, 5);      // id 0 with 5 cycles backpressure
    lookup(1'b0, 11, rand_line(), 0, 1, 0, 0, 0); // flush at accept blocks hit

    // reset in the middle of a read, then a stray R beat drained in IDLE
    @(negedge clk_i);
    req_valid_i = 1'b1; req_type_i = 1'b1; req_id_i = 20'd77;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("midrst_ar", ar_valid_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    m_vld[0] = 1'b0; m_vld[1] = 1'b0;
    chk("midrst_idle", req_ready_o, 1);
    chk("midrst_ar_off", ar_valid_o, 0);
    chk("midrst_rsp_off", rsp_valid_o, 0);
    r_valid_i = 1'b1; r_data_i = rand_line(); r_resp_i = 2'b00; r_last_i = 1'b1;
    #1;
    chk("stray_r_ready", r_ready_o, 1);
    @(negedge clk_i);
    r_valid_i = 1'b0;
    chk("stray_rsp_off", rsp_valid_o, 0);
    chk("stray_idle", req_ready_o, 1);

    // randomized traffic over a small ID range so hits are frequent
    for (int n = 0; n < 150; n++) begin
      lookup(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), rand_line(),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
